// File: rtl/chip_phase_serializer_if.sv
// Symbol handshake between the frame source and chip_phase_serializer.
//   i_sym_valid : source offers a symbol
//   i_sym       : 4-bit ZigBee symbol, held stable until accepted
//   o_sym_ready : serializer can take a symbol this cycle
// Modports:
//   master : symbol source
//   slave  : serializer
interface chip_phase_serializer_if;
  logic       i_sym_valid;
  logic [3:0] i_sym;
  logic       o_sym_ready;

  modport master (output i_sym_valid, output i_sym, input o_sym_ready);
  modport slave  (input i_sym_valid, input i_sym, output o_sym_ready);
endinterface

// File: rtl/chip_phase_serializer.sv
// Maps 4-bit ZigBee symbols to their 32-chip PN sequences and serializes the
// chips onto o_phase, c0 first. Each chip is held for N = max(i_nb_P, 2)
// cycles, with N latched when the symbol is accepted.
// Ports:
//   i_clk, i_rst       : clock, asynchronous active-low reset
//   i_nb_P             : cycles per chip, sampled at symbol acceptance
//   sym_if (slave)     : i_sym_valid / i_sym / o_sym_ready handshake
//   o_phase            : chip stream, 0 when idle
//   o_chip_strobe      : pulse on the first cycle of every chip
//   o_sym_done         : pulse on the last cycle of chip 31
//   o_busy             : a symbol is being emitted
module chip_phase_serializer #(
  parameter int CHIPS_PER_SYM = 32,
  parameter int NB_P_W        = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_P_W-1:0]     i_nb_P,
  chip_phase_serializer_if.slave sym_if,
  output logic                  o_phase,
  output logic                  o_chip_strobe,
  output logic                  o_sym_done,
  output logic                  o_busy
);
  localparam int CW = $clog2(CHIPS_PER_SYM);
  localparam logic [CW-1:0] LAST_CHIP = CW'(CHIPS_PER_SYM - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state_q, state_d;
  logic [CHIPS_PER_SYM-1:0]   sreg_q, sreg_d;
  logic [NB_P_W-1:0]          nb_q, nb_d;
  logic [NB_P_W-1:0]          cyc_q, cyc_d;
  logic [CW-1:0]              chip_q, chip_d;
  // Keeps o_sym_ready low until the first edge after reset release.
  logic                       rdy_en_q;

  logic [CHIPS_PER_SYM-1:0]   lut_chips;
  logic [NB_P_W-1:0]          nb_last;
  logic                       chip_end, sym_last, sym_ready, accept;

  // Symbols 0..7 are rotations of symbol 0; bit 3 inverts the odd chips.
  always_comb begin
    lut_chips = '0;
    case (sym_if.i_sym[2:0])
      3'd0: lut_chips = 32'hD9C3522E;
      3'd1: lut_chips = 32'hED9C3522;
      3'd2: lut_chips = 32'h2ED9C352;
      3'd3: lut_chips = 32'h22ED9C35;
      3'd4: lut_chips = 32'h522ED9C3;
      3'd5: lut_chips = 32'h3522ED9C;
      3'd6: lut_chips = 32'hC3522ED9;
      3'd7: lut_chips = 32'h9C3522ED;
      default: lut_chips = '0;
    endcase
    if (sym_if.i_sym[3]) lut_chips = lut_chips ^ 32'h55555555;
  end

  assign nb_last   = nb_q - 1'b1;
  assign chip_end  = (state_q == SEND) && (cyc_q == nb_last);
  assign sym_last  = chip_end && (chip_q == LAST_CHIP);
  assign sym_ready = rdy_en_q && ((state_q == IDLE) || sym_last);
  assign accept    = sym_if.i_sym_valid && sym_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    nb_d    = nb_q;
    cyc_d   = cyc_q;
    chip_d  = chip_q;
    if (accept) begin
      // Reload also covers the back-to-back case on the last cycle of chip 31.
      state_d = SEND;
      sreg_d  = lut_chips;
      nb_d    = (i_nb_P < NB_P_W'(2)) ? NB_P_W'(2) : i_nb_P;
      cyc_d   = '0;
      chip_d  = '0;
    end else if (state_q == SEND) begin
      if (chip_end) begin
        cyc_d = '0;
        if (sym_last) begin
          state_d = IDLE;
        end else begin
          sreg_d = {sreg_q[CHIPS_PER_SYM-2:0], 1'b0};
          chip_d = chip_q + 1'b1;
        end
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      nb_q     <= '0;
      cyc_q    <= '0;
      chip_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      nb_q     <= nb_d;
      cyc_q    <= cyc_d;
      chip_q   <= chip_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign sym_if.o_sym_ready = sym_ready;
  assign o_busy        = (state_q == SEND);
  assign o_phase       = (state_q == SEND) && sreg_q[CHIPS_PER_SYM-1];
  assign o_chip_strobe = (state_q == SEND) && (cyc_q == '0);
  assign o_sym_done    = sym_last;
endmodule

// File: tb/tb_chip_phase_serializer.sv
module tb_chip_phase_serializer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] nb_P = 6'd4;
  logic       o_phase, o_chip_strobe, o_sym_done, o_busy;
  logic       rdy_ok = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct packed { logic ph; logic st; logic dn; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic mon_busy, mon_rdy;

  chip_phase_serializer_if sif ();

  chip_phase_serializer #(.CHIPS_PER_SYM(32), .NB_P_W(6)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_nb_P(nb_P), .sym_if(sif.slave),
    .o_phase(o_phase), .o_chip_strobe(o_chip_strobe),
    .o_sym_done(o_sym_done), .o_busy(o_busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference chip table: rotate symbol 0 right by 4*s, invert odd chips for s>=8.
  function automatic logic [31:0] ref_chips(input logic [3:0] s);
    logic [31:0] b = 32'hD9C3522E;
    for (int i = 0; i < 4 * int'(s[2:0]); i++) b = {b[0], b[31:1]};
    if (s[3]) b = b ^ 32'h55555555;
    return b;
  endfunction

  function automatic void push_sym(input logic [3:0] s, input logic [5:0] nb);
    int n = (nb < 2) ? 2 : int'(nb);
    logic [31:0] c = ref_chips(s);
    for (int ci = 0; ci < 32; ci++)
      for (int j = 0; j < n; j++)
        q.push_back('{ph: c[31-ci], st: (j == 0), dn: (ci == 31 && j == n - 1)});
  endfunction

  // Ready is expected from the first edge after reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) rdy_ok <= 1'b0; else rdy_ok <= 1'b1;

  // Scoreboard push on every accepted symbol.
  always @(posedge clk)
    if (rst_n && sif.i_sym_valid && sif.o_sym_ready) push_sym(sif.i_sym, nb_P);

  // Scoreboard pop/compare every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      mon_busy = 1'b1;
      mon_rdy = mon_e.dn;
    end else begin
      mon_e = '0;
      mon_busy = 1'b0;
      mon_rdy = rdy_ok;
    end
    chk("busy",   o_busy,          mon_busy);
    chk("phase",  o_phase,         mon_e.ph);
    chk("strobe", o_chip_strobe,   mon_e.st);
    chk("done",   o_sym_done,      mon_e.dn);
    chk("ready",  sif.o_sym_ready, mon_rdy);
  end

  // Offer a symbol and return just after the accepting edge; valid stays high.
  task automatic offer(input logic [3:0] s, input logic [5:0] nb);
    int t = 0;
    @(negedge clk);
    sif.i_sym_valid = 1'b1;
    sif.i_sym = s;
    nb_P = nb;
    while (!sif.o_sym_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_chk++; n_fail++;
      $error("FAIL offer_timeout observed=not_ready expected=ready sym=%0d", s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (o_busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_chk++; n_fail++;
      $error("FAIL idle_timeout observed=busy expected=idle");
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    sif.i_sym_valid = 1'b0;
    sif.i_sym = 4'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_phase", o_phase, 1'b0);
    chk("rst_ready", sif.o_sym_ready, 1'b0);
    #1 rst_n = 1'b1;
    #1 chk("rel_ready_pre_edge", sif.o_sym_ready, 1'b0);
    repeat (2) @(negedge clk);

    // Symbol 0, 4-cycle chips.
    offer(4'd0, 6'd4);
    sif.i_sym_valid = 1'b0;
    wait_idle();

    // Back-to-back 1 then 8 with valid held high.
    offer(4'd1, 6'd2);
    offer(4'd8, 6'd2);
    sif.i_sym_valid = 1'b0;
    wait_idle();

    // Clamped chip periods.
    offer(4'd15, 6'd0);
    sif.i_sym_valid = 1'b0;
    wait_idle();
    offer(4'd7, 6'd1);
    sif.i_sym_valid = 1'b0;
    wait_idle();

    // i_nb_P change mid-symbol; next symbol offered mid-symbol with a new value.
    offer(4'd3, 6'd4);
    sif.i_sym_valid = 1'b0;
    repeat (21) @(negedge clk);
    nb_P = 6'd10;
    offer(4'd5, 6'd10);
    sif.i_sym_valid = 1'b0;
    wait_idle();

    // Asynchronous reset at chip 17, between edges.
    offer(4'd6, 6'd4);
    sif.i_sym_valid = 1'b0;
    repeat (17 * 4 + 1) @(negedge clk);
    #3 rst_n = 1'b0;
    q.delete();
    #1;
    chk("arst_phase",  o_phase, 1'b0);
    chk("arst_busy",   o_busy, 1'b0);
    chk("arst_strobe", o_chip_strobe, 1'b0);
    chk("arst_done",   o_sym_done, 1'b0);
    chk("arst_ready",  sif.o_sym_ready, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rel_ready_post_edge", sif.o_sym_ready, 1'b1);
    offer(4'd2, 6'd3);
    sif.i_sym_valid = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
